mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_pkg.sv | 30 +++
 rtl/mem_req_arbiter_select.sv | 30 +++
 rtl/mem_req_arbiter.sv | 98 +++++++++
 tb/tb_mem_req_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory-side request arbiter: cbus request/response structs,
// FSM state encoding and requester port indices.
package mem_req_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   localparam int unsigned MEM_REQ_DATA   = 0;
   localparam int unsigned MEM_REQ_IFETCH = 1;
   localparam int unsigned MEM_REQ_PTW    = 2;
   localparam int unsigned MEM_REQ_NUM    = 3;

   // len is beats-minus-one: len=0 is a single-beat transaction
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [3:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] rdata;
   } cbus_resp_t;

endpackage

// File: rtl/mem_req_arbiter_select.sv
// Combinational rotating-priority picker: first valid requester at or after base_i,
// wrapping modulo NUM_REQ. Tying base_i to 0 gives plain lowest-index-wins priority.
module arb_priority_select #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   base_i,
   output logic               any_valid_o,
   output logic [IDX_W-1:0]   winner_o
);

   logic [NUM_REQ-1:0] rotated;
   logic [IDX_W:0]     offset;
   logic [IDX_W:0]     sum;

   always_comb begin
      rotated     = NUM_REQ'({valid_i, valid_i} >> base_i);
      any_valid_o = |valid_i;
      offset      = '0;
      // descending scan so the lowest rotated position is the one left standing
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         if (rotated[i-1]) offset = (IDX_W+1)'(i - 1);
      end
      sum = {1'b0, base_i} + offset;
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      winner_o = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-transaction cbus arbiter for data / ifetch / PTW requesters; grant held until last beat.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority (lowest index wins).
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = MEM_REQ_NUM,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  cbus_req_t        ireqs  [NUM_REQ],
   output cbus_resp_t       iresps [NUM_REQ],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);

   arb_state_t         state_q;
   logic               busy_q;
   logic [IDX_W-1:0]   grant_idx_q;
   logic [IDX_W-1:0]   base;
   logic [IDX_W-1:0]   winner;
   logic               any_valid;
   logic [NUM_REQ-1:0] req_valid;
   cbus_req_t          granted_req;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) req_valid[i] = ireqs[i].valid;
   end

   arb_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_select (
      .valid_i     (req_valid),
      .base_i      (base),
      .any_valid_o (any_valid),
      .winner_o    (winner)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;

   assign rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (reset)                                  rr_ptr_q <= '0;
      else if (state_q == ARB_IDLE && any_valid) rr_ptr_q <= rr_ptr_d;
   end

   assign base = rr_ptr_q;
`else
   assign base = '0;
`endif

   assign granted_req = ireqs[grant_idx_q];

   // abort (granted valid dropped) and final beat both end the transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         busy_q      <= 1'b0;
         grant_idx_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (any_valid) begin
                  state_q     <= ARB_BUSY;
                  busy_q      <= 1'b1;
                  grant_idx_q <= winner;
               end
            end
            ARB_BUSY: begin
               if (!granted_req.valid || (oresp.ready && oresp.last)) begin
                  state_q <= ARB_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      oreq = (state_q == ARB_BUSY) ? granted_req : '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) iresps[i] = '0;
      if (state_q == ARB_BUSY) iresps[grant_idx_q] = oresp;
   end

   assign busy      = busy_q;
   assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a transaction-level ownership model.
// Honors ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   cbus_req_t     ireqs  [N];
   cbus_resp_t    iresps [N];
   cbus_req_t     oreq;
   cbus_resp_t    oresp;
   logic          busy;
   logic [IW-1:0] grant_idx;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   mem_req_arbiter #(
      .NUM_REQ (N),
      .IDX_W   (IW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Requester-side transaction state and the model's view of bus ownership
   logic        r_valid [N];
   logic        r_we    [N];
   logic [3:0]  r_len   [N];
   logic [31:0] r_addr  [N];
   logic [31:0] r_wdata [N];
   int          r_beat  [N];
   int          owner;       // -1 when nobody holds the bus
   int          last_grant;
   int          rr;

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int p = (rr + k) % N;
         if (r_valid[p]) return p;
      end
      return -1;
   endfunction

   task automatic compare_outputs();
      cbus_req_t  exp_req;
      cbus_resp_t exp_resp;
      exp_req = (owner >= 0) ? ireqs[owner] : '0;
      check_eq("busy", 128'(busy), 128'(owner >= 0));
      check_eq("grant_idx", 128'(grant_idx), 128'(last_grant));
      check_eq("oreq", 128'(oreq), 128'(exp_req));
      for (int p = 0; p < N; p++) begin
         exp_resp = (owner == p) ? oresp : '0;
         check_eq($sformatf("iresps[%0d]", p), 128'(iresps[p]), 128'(exp_resp));
      end
   endtask

   initial begin
      logic do_rst;
      logic rdy;
      int   w;

      reset = 1'b1;
      oresp = '0;
      for (int p = 0; p < N; p++) begin
         ireqs[p]   = '0;
         r_valid[p] = 1'b0;
         r_we[p]    = 1'b0;
         r_len[p]   = '0;
         r_addr[p]  = '0;
         r_wdata[p] = '0;
         r_beat[p]  = 0;
      end
      owner      = -1;
      last_grant = 0;
      rr         = 0;

      repeat (3) @(negedge clk);
      compare_outputs();
      reset = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < N; p++) begin
            if (!r_valid[p] && $urandom_range(3) == 0) begin
               r_valid[p] = 1'b1;
               r_we[p]    = 1'($urandom);
               r_len[p]   = 4'($urandom_range(3));
               r_addr[p]  = $urandom;
               r_wdata[p] = $urandom;
               r_beat[p]  = 0;
            end
         end
         if (owner >= 0 && r_valid[owner] && $urandom_range(29) == 0) begin
            r_valid[owner] = 1'b0;
            r_beat[owner]  = 0;
         end
         for (int p = 0; p < N; p++) begin
            ireqs[p].valid = r_valid[p];
            ireqs[p].we    = r_we[p];
            ireqs[p].len   = r_len[p];
            ireqs[p].addr  = r_addr[p];
            ireqs[p].wdata = r_wdata[p];
         end
         if (owner >= 0 && r_valid[owner]) begin
            rdy         = ($urandom_range(2) != 0);
            oresp.ready = rdy;
            oresp.last  = rdy && (r_beat[owner] == int'(r_len[owner]));
            oresp.rdata = $urandom;
         end else begin
            oresp.ready = 1'($urandom);
            oresp.last  = 1'($urandom);
            oresp.rdata = $urandom;
         end
         do_rst = (cyc % 500 == 250) || (owner >= 0 && $urandom_range(199) == 0);
         reset  = do_rst;

         #1;
         compare_outputs();

         // Effect of the upcoming rising edge
         if (do_rst) begin
            if (owner >= 0) begin
               r_valid[owner] = 1'b0;
               r_beat[owner]  = 0;
            end
            owner      = -1;
            last_grant = 0;
            rr         = 0;
         end else if (owner >= 0) begin
            if (!r_valid[owner]) begin
               owner = -1;
            end else if (oresp.ready) begin
               if (oresp.last) begin
                  r_valid[owner] = 1'b0;
                  r_beat[owner]  = 0;
                  owner          = -1;
               end else begin
                  r_beat[owner]++;
               end
            end
         end else begin
            w = pick();
            if (w >= 0) begin
               owner      = w;
               last_grant = w;
`ifdef ARB_ROUND_ROBIN_EN
               rr = (w + 1) % N;
`endif
            end
         end
      end

      @(negedge clk);
      reset = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
